// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundle of the write-back request side and the register-file write side of the
//   register write-port arbiter.
//   slave  : arbiter view. It receives the requests and drives the write port.
//   master : requester / register-file view, the mirror image of slave.
// Signals
//   req_valid [3:0]     per-requester request (ALU, load, link, aux)
//   req_ready [3:0]     one-hot accept
//   req_data  [4*DW]    requester i data at [i*DATA_W +: DATA_W]
//   rt_field / rd_field / aux_field   destination register sources
//   rf_busy             register file cannot take a write this cycle
//   wr_sel, reg_write, wr_data, wr_dst, grant_id, drop_cnt   write-port outputs
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [3:0]          req_valid;
    logic [3:0]          req_ready;
    logic [4*DATA_W-1:0] req_data;
    logic [4:0]          rt_field;
    logic [4:0]          rd_field;
    logic [4:0]          aux_field;
    logic                rf_busy;
    logic [1:0]          wr_sel;
    logic                reg_write;
    logic [DATA_W-1:0]   wr_data;
    logic [4:0]          wr_dst;
    logic [1:0]          grant_id;
    logic [7:0]          drop_cnt;

    modport slave (
        input  req_valid, req_data, rt_field, rd_field, aux_field, rf_busy,
        output req_ready, wr_sel, reg_write, wr_data, wr_dst, grant_id, drop_cnt
    );

    modport master (
        output req_valid, req_data, rt_field, rd_field, aux_field, rf_busy,
        input  req_ready, wr_sel, reg_write, wr_data, wr_dst, grant_id, drop_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates the single register-file write port between four write-back
//   requesters (0=ALU->rd, 1=load->rt, 2=link->$ra, 3=aux->aux_field). The
//   arbitration is round-robin, and the link requester can optionally take priority.
//   There is one registered output stage. The output holds while rf_busy is high.
//   Writes to $zero can be accepted and then dropped, and each drop is counted.
// Parameters
//   DATA_W         write data width
//   LINK_PRIO      1: requester 2 beats all others; 0: pure round-robin
//   ZERO_SUPPRESS  1: requests resolving to register 0 are accepted but not issued
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    wb_port_arbiter_if.slave. It carries the requests, the destination
//          fields, rf_busy and the write-port outputs.
module wb_port_arbiter #(
    parameter int DATA_W        = 32,
    parameter int LINK_PRIO     = 1,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                clk,
    input  logic                reset,
    wb_port_arbiter_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          rr_ptr_q;
    logic [7:0]          drop_cnt_q;

    logic                any_vld_p0;
    logic                can_accept_p0;
    logic                accept_p0;
    logic                suppress_p0;
    logic                load_p0;
    logic                drop_p0;
    logic [1:0]          win_p0;
    logic [1:0]          sel_p0;
    logic [4:0]          dst_p0;
    logic [DATA_W-1:0]   data_p0;

    logic [DATA_W-1:0]   wr_data_p1;
    logic [1:0]          wr_sel_p1;
    logic [4:0]          wr_dst_p1;
    logic [1:0]          grant_p1;

    // Searches upward from ptr, modulo 4. The loop runs from the largest offset
    // down to 0, so the last assignment is the valid requester nearest to ptr.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (valid[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---- stage p0: arbitration and destination resolve (combinational) ----
    always_comb begin
        any_vld_p0 = |bus.req_valid;

        if ((LINK_PRIO != 0) && bus.req_valid[2]) begin
            win_p0 = 2'd2;
        end else begin
            win_p0 = rr_pick(bus.req_valid, rr_ptr_q);
        end

        dst_p0 = bus.aux_field;
        unique case (win_p0)
            2'd0: dst_p0 = bus.rd_field;
            2'd1: dst_p0 = bus.rt_field;
            2'd2: dst_p0 = 5'd31;
            2'd3: dst_p0 = bus.aux_field;
            default: dst_p0 = bus.aux_field;
        endcase

        // Requester i drives mux input 3-i, which is the bitwise inverse of i.
        sel_p0  = ~win_p0;
        data_p0 = bus.req_data[win_p0*DATA_W +: DATA_W];

        // Reset is included here so that req_ready is 0 while reset is held.
        can_accept_p0 = reset && ((state_q == IDLE) || !bus.rf_busy);
        accept_p0     = can_accept_p0 && any_vld_p0;
        suppress_p0   = (ZERO_SUPPRESS != 0) && (dst_p0 == 5'd0);
        load_p0       = accept_p0 && !suppress_p0;
        drop_p0       = accept_p0 && suppress_p0;
    end

    assign bus.req_ready = accept_p0 ? (4'b0001 << win_p0) : 4'b0000;

    // ---- FSM next state ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_p0) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!bus.rf_busy) begin
                    state_d = load_p0 ? WRITE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- control registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 2'd0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            // With link priority and a link win, w+1 equals 3, so one rule covers both modes.
            if (accept_p0) begin
                rr_ptr_q <= win_p0 + 2'd1;
            end
            if (drop_p0) begin
                drop_cnt_q <= sat_inc8(drop_cnt_q);
            end
        end
    end

    // ---- stage p1: registered write port ----
    // The data registers are reset as well, so that every output reads 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_data_p1 <= '0;
            wr_sel_p1  <= 2'd0;
            wr_dst_p1  <= 5'd0;
            grant_p1   <= 2'd0;
        end else if (load_p0) begin
            wr_data_p1 <= data_p0;
            wr_sel_p1  <= sel_p0;
            wr_dst_p1  <= dst_p0;
            grant_p1   <= win_p0;
        end
    end

    assign bus.reg_write = (state_q == WRITE);
    assign bus.wr_data   = wr_data_p1;
    assign bus.wr_sel    = wr_sel_p1;
    assign bus.wr_dst    = wr_dst_p1;
    assign bus.grant_id  = grant_p1;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter. There are two instances: dut_rr
//   (LINK_PRIO=0) and dut_lp (LINK_PRIO=1). Each instance has its own interface.
//   Inputs change 1ns after the rising edge, and outputs are sampled on the falling edge.
module tb_wb_port_arbiter;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(DATA_W)) bus_rr ();
    wb_port_arbiter_if #(.DATA_W(DATA_W)) bus_lp ();

    wb_port_arbiter #(.DATA_W(DATA_W), .LINK_PRIO(0), .ZERO_SUPPRESS(1)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_rr.slave)
    );

    wb_port_arbiter #(.DATA_W(DATA_W), .LINK_PRIO(1), .ZERO_SUPPRESS(1)) dut_lp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_lp.slave)
    );

    int errors = 0;
    int checks = 0;
    int commits = 0;
    int commits_tag = 0;
    int n0 = 0;
    int n1 = 0;

    localparam logic [31:0] TAG_DATA = 32'h0000_1234;

    // Counts the commits of dut_rr (reg_write & !rf_busy at the rising edge).
    always @(posedge clk) begin
        if (bus_rr.reg_write && !bus_rr.rf_busy) begin
            commits <= commits + 1;
            if (bus_rr.wr_data == TAG_DATA) begin
                commits_tag <= commits_tag + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] exp_dst [4];
        exp_dst[0] = 5'd5;
        exp_dst[1] = 5'd6;
        exp_dst[2] = 5'd31;
        exp_dst[3] = 5'd7;

        reset = 1'b0;
        bus_rr.req_valid = 4'b1111;
        bus_lp.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus_rr.req_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(i);
            bus_lp.req_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(i);
        end
        bus_rr.rd_field = 5'd5; bus_rr.rt_field = 5'd6; bus_rr.aux_field = 5'd7;
        bus_lp.rd_field = 5'd5; bus_lp.rt_field = 5'd6; bus_lp.aux_field = 5'd7;
        bus_rr.rf_busy = 1'b0;
        bus_lp.rf_busy = 1'b0;

        // 1: reset held with all requests valid, then released
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus_rr.req_ready), 32'h0);
        chk("rst_regwrite", 32'(bus_rr.reg_write), 32'h0);
        chk("rst_dropcnt", 32'(bus_rr.drop_cnt), 32'h0);
        chk("rst_wrdata", bus_rr.wr_data, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("first_grant_rr", 32'(bus_rr.req_ready), 32'h1);
        chk("first_grant_lp", 32'(bus_lp.req_ready), 32'h4);

        // 2: round-robin with every requester valid
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rr_regwrite", 32'(bus_rr.reg_write), 32'h1);
            chk("rr_sel", 32'(bus_rr.wr_sel), 32'(3 - (k % 4)));
            chk("rr_grant", 32'(bus_rr.grant_id), 32'(k % 4));
            chk("rr_data", bus_rr.wr_data, 32'hA000_0000 + 32'(k % 4));
            chk("rr_dst", 32'(bus_rr.wr_dst), 32'(exp_dst[k % 4]));
            chk("rr_ready", 32'(bus_rr.req_ready), 32'(1 << ((k + 1) % 4)));
        end
        @(posedge clk); #1;
        bus_rr.req_valid = 4'b0000;
        bus_lp.req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rr_idle", 32'(bus_rr.reg_write), 32'h0);

        // 3: link priority, with req0 and req2 both pending
        @(posedge clk); #1 bus_lp.req_valid = 4'b0101;
        @(negedge clk);
        chk("lp_ready_link", 32'(bus_lp.req_ready), 32'h4);
        @(posedge clk); #1 bus_lp.req_valid = 4'b0001;
        @(negedge clk);
        chk("lp_sel_link", 32'(bus_lp.wr_sel), 32'h1);
        chk("lp_dst_link", 32'(bus_lp.wr_dst), 32'd31);
        chk("lp_ready_alu", 32'(bus_lp.req_ready), 32'h1);
        @(posedge clk); #1 bus_lp.req_valid = 4'b0000;
        @(negedge clk);
        chk("lp_sel_alu", 32'(bus_lp.wr_sel), 32'h3);
        chk("lp_dst_alu", 32'(bus_lp.wr_dst), 32'd5);
        chk("lp_grant_alu", 32'(bus_lp.grant_id), 32'h0);

        // 4: rf_busy stall while a write is held
        @(posedge clk); #1;
        bus_rr.req_data[0 +: DATA_W] = TAG_DATA;
        bus_rr.req_valid = 4'b0001;
        @(negedge clk);
        chk("stall_accept", 32'(bus_rr.req_ready), 32'h1);
        @(posedge clk); #1;
        bus_rr.req_valid = 4'b0010;
        bus_rr.rf_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_regwrite", 32'(bus_rr.reg_write), 32'h1);
            chk("stall_data", bus_rr.wr_data, TAG_DATA);
            chk("stall_sel", 32'(bus_rr.wr_sel), 32'h3);
            chk("stall_ready", 32'(bus_rr.req_ready), 32'h0);
            @(posedge clk); #1;
        end
        bus_rr.rf_busy = 1'b0;
        @(negedge clk);
        chk("unstall_ready", 32'(bus_rr.req_ready), 32'h2);
        chk("unstall_data", bus_rr.wr_data, TAG_DATA);
        @(posedge clk); #1 bus_rr.req_valid = 4'b0000;
        @(negedge clk);
        chk("b2b_data", bus_rr.wr_data, 32'hA000_0001);
        chk("b2b_sel", 32'(bus_rr.wr_sel), 32'h2);
        chk("tag_commits", 32'(commits_tag), 32'd1);

        // 5: suppression of writes to $zero, and saturation of drop_cnt
        @(posedge clk); #1;
        bus_rr.rt_field = 5'd0;
        bus_rr.req_valid = 4'b0010;
        @(negedge clk);
        chk("zero_ready", 32'(bus_rr.req_ready), 32'h2);
        n0 = commits;
        @(posedge clk);
        @(negedge clk);
        chk("zero_regwrite", 32'(bus_rr.reg_write), 32'h0);
        chk("zero_dropcnt1", 32'(bus_rr.drop_cnt), 32'd1);
        repeat (299) @(posedge clk);
        #1 bus_rr.req_valid = 4'b0000;
        @(negedge clk);
        chk("zero_dropcnt_sat", 32'(bus_rr.drop_cnt), 32'd255);
        chk("zero_regwrite_end", 32'(bus_rr.reg_write), 32'h0);
        chk("zero_no_commit", 32'(commits), 32'(n0));

        // 6: reset asserted while a write is in flight
        @(posedge clk); #1;
        bus_rr.rt_field = 5'd6;
        bus_rr.req_valid = 4'b0001;
        @(posedge clk); #1;
        bus_rr.req_valid = 4'b0000;
        bus_rr.rf_busy = 1'b1;
        @(negedge clk);
        chk("mid_regwrite", 32'(bus_rr.reg_write), 32'h1);
        n1 = commits;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_regwrite", 32'(bus_rr.reg_write), 32'h0);
        chk("mid_rst_dropcnt", 32'(bus_rr.drop_cnt), 32'h0);
        chk("mid_rst_data", bus_rr.wr_data, 32'h0);
        @(posedge clk); #1;
        bus_rr.rf_busy = 1'b0;
        chk("mid_rst_no_commit", 32'(commits), 32'(n1));
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(bus_rr.reg_write), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
